// File: rtl/chamber_chain_pkg.sv
// Shared types and helpers for the microfluidic chamber-chain sequencer.
package chamber_chain_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    FILLING  = 3'd1,
    DWELL    = 3'd2,
    WAIT     = 3'd3,
    DRAINING = 3'd4
  } chamber_state_e;

  // Width needed to count 0..n samples.
  function automatic int occ_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chain_stage.sv
// One chamber of the chain: state machine plus the tag/dwell of the sample it holds.
module chain_stage
  import chamber_chain_pkg::*;
#(
  parameter int TAG_W       = 8,
  parameter int DWELL_W     = 8,
  parameter int XFER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               fill_go,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [DWELL_W-1:0] fill_dwell,
  input  logic               drain_go,
  output chamber_state_e     state,
  output logic               xdone,
  output logic [TAG_W-1:0]   tag,
  output logic [DWELL_W-1:0] dwell
);

  localparam int            XW    = $clog2(XFER_CYCLES + 1);
  localparam logic [XW-1:0] XLOAD = XW'(XFER_CYCLES - 1);

  logic [XW-1:0]      xcnt;
  logic [DWELL_W-1:0] dcnt;

  assign xdone = (xcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      xcnt  <= '0;
      dcnt  <= '0;
    end else if (!pause) begin
      unique case (state)
        EMPTY: begin
          if (fill_go) begin
            state <= FILLING;
            xcnt  <= XLOAD;
          end
        end
        FILLING: begin
          if (xdone) begin
            state <= DWELL;
            dcnt  <= dwell;
          end else begin
            xcnt <= xcnt - XW'(1);
          end
        end
        DWELL: begin
          if (dcnt == '0) state <= WAIT;
          else            dcnt  <= dcnt - DWELL_W'(1);
        end
        WAIT: begin
          // Draining runs in lockstep with the destination's filling.
          if (drain_go) begin
            state <= DRAINING;
            xcnt  <= XLOAD;
          end
        end
        DRAINING: begin
          if (xdone) state <= EMPTY;
          else       xcnt  <= xcnt - XW'(1);
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Sample payload is data only; it is meaningful solely while the chamber is occupied.
  always_ff @(posedge clk) begin
    if (!pause && fill_go && state == EMPTY) begin
      tag   <= fill_tag;
      dwell <= fill_dwell;
    end
  end

endmodule

// File: rtl/chamber_chain_seq.sv
// Sequencer for a linear chain of chambers: ingress/egress glue, stage linking,
// valve vector and occupancy counter.
module chamber_chain_seq
  import chamber_chain_pkg::*;
#(
  parameter int NUM_CHAMBERS = 32,
  parameter int TAG_W        = 8,
  parameter int DWELL_W      = 8,
  parameter int XFER_CYCLES  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pause,
  input  logic                               in_valid,
  input  logic [TAG_W-1:0]                   in_tag,
  input  logic [DWELL_W-1:0]                 in_dwell,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic [TAG_W-1:0]                   out_tag,
  input  logic                               out_ready,
  output logic [NUM_CHAMBERS:0]              valve_open,
  output logic [occ_w(NUM_CHAMBERS)-1:0]     occupancy,
  output logic                               busy
);

  localparam int N  = NUM_CHAMBERS;
  localparam int OW = occ_w(NUM_CHAMBERS);

  chamber_state_e                state_v [N];
  logic [N-1:0]                  fill_go;
  logic [N-1:0]                  drain_go;
  logic [N-1:0]                  xdone_v;
  logic [N-1:0]                  filling_v;
  logic [N-1:0][TAG_W-1:0]       tag_v;
  logic [N-1:0][TAG_W-1:0]       fill_tag_v;
  logic [N-1:0][DWELL_W-1:0]     dwell_v;
  logic [N-1:0][DWELL_W-1:0]     fill_dwell_v;
  logic                          in_hs;
  logic                          out_hs;
  logic                          out_done;
  logic [OW-1:0]                 occ_q;
  logic                          unused_bits;

  assign in_ready  = !rst && !pause && (state_v[0] == EMPTY);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = !pause && (state_v[N-1] == WAIT);
  assign out_tag   = out_valid ? tag_v[N-1] : '0;
  assign out_hs    = out_valid && out_ready;

  for (genvar k = 0; k < N; k++) begin : g_stage
    chain_stage #(
      .TAG_W      (TAG_W),
      .DWELL_W    (DWELL_W),
      .XFER_CYCLES(XFER_CYCLES)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .pause     (pause),
      .fill_go   (fill_go[k]),
      .fill_tag  (fill_tag_v[k]),
      .fill_dwell(fill_dwell_v[k]),
      .drain_go  (drain_go[k]),
      .state     (state_v[k]),
      .xdone     (xdone_v[k]),
      .tag       (tag_v[k]),
      .dwell     (dwell_v[k])
    );

    assign filling_v[k] = (state_v[k] == FILLING);

    if (k == 0) begin : g_head
      assign fill_go[k]      = in_hs;
      assign fill_tag_v[k]   = in_tag;
      assign fill_dwell_v[k] = in_dwell;
    end else begin : g_link
      assign fill_go[k]      = drain_go[k-1];
      assign fill_tag_v[k]   = tag_v[k-1];
      assign fill_dwell_v[k] = dwell_v[k-1];
    end

    if (k == N - 1) begin : g_tail
      assign drain_go[k] = out_hs;
    end else begin : g_mid
      // A chamber emptied on the previous edge is already visible as free here.
      assign drain_go[k] = !pause && (state_v[k] == WAIT) && (state_v[k+1] == EMPTY);
    end
  end

  // A sample leaves the chain's ownership when the outlet drain finishes.
  assign out_done = !pause && (state_v[N-1] == DRAINING) && xdone_v[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (in_hs && !out_done) begin
      occ_q <= occ_q + OW'(1);
    end else if (!in_hs && out_done) begin
      occ_q <= occ_q - OW'(1);
    end
  end

  assign occupancy   = occ_q;
  assign busy        = (occ_q != '0);
  assign valve_open  = {(state_v[N-1] == DRAINING), filling_v};
  assign unused_bits = ^{xdone_v, dwell_v[N-1]};

endmodule

// File: tb/tb_chamber_chain_seq.sv
// Directed bench: timing, back-pressure, pause, reset and a full-length stream.
module tb_chamber_chain_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // dut_a: N=4, X=2
  logic       a_rst = 1'b1, a_pause = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [7:0] a_in_tag = '0, a_in_dwell = '0;
  logic       a_in_ready, a_out_valid, a_busy;
  logic [7:0] a_out_tag;
  logic [4:0] a_valve;
  logic [2:0] a_occ;

  chamber_chain_seq #(.NUM_CHAMBERS(4), .TAG_W(8), .DWELL_W(8), .XFER_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(a_rst), .pause(a_pause), .in_valid(a_in_valid), .in_tag(a_in_tag),
    .in_dwell(a_in_dwell), .in_ready(a_in_ready), .out_valid(a_out_valid), .out_tag(a_out_tag),
    .out_ready(a_out_ready), .valve_open(a_valve), .occupancy(a_occ), .busy(a_busy)
  );

  // dut_b: N=1, X=1
  logic       b_rst = 1'b1, b_pause = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0] b_in_tag = '0, b_in_dwell = '0;
  logic       b_in_ready, b_out_valid, b_busy;
  logic [7:0] b_out_tag;
  logic [1:0] b_valve;
  logic [0:0] b_occ;

  chamber_chain_seq #(.NUM_CHAMBERS(1), .TAG_W(8), .DWELL_W(8), .XFER_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .pause(b_pause), .in_valid(b_in_valid), .in_tag(b_in_tag),
    .in_dwell(b_in_dwell), .in_ready(b_in_ready), .out_valid(b_out_valid), .out_tag(b_out_tag),
    .out_ready(b_out_ready), .valve_open(b_valve), .occupancy(b_occ), .busy(b_busy)
  );

  // dut_c: default parameters
  logic        c_rst = 1'b1, c_pause = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [7:0]  c_in_tag = '0, c_in_dwell = '0;
  logic        c_in_ready, c_out_valid, c_busy;
  logic [7:0]  c_out_tag;
  logic [32:0] c_valve;
  logic [5:0]  c_occ;

  chamber_chain_seq u_dut_c (
    .clk(clk), .rst(c_rst), .pause(c_pause), .in_valid(c_in_valid), .in_tag(c_in_tag),
    .in_dwell(c_in_dwell), .in_ready(c_in_ready), .out_valid(c_out_valid), .out_tag(c_out_tag),
    .out_ready(c_out_ready), .valve_open(c_valve), .occupancy(c_occ), .busy(c_busy)
  );

  // Expected dut_a valve vector o cycles after an ingress handshake, dwell=3, P=7.
  function automatic logic [4:0] exp_valve_a(input int o);
    logic [4:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k] = (o == 7*k + 1) || (o == 7*k + 2);
    v[4] = (o == 29) || (o == 30);
    return v;
  endfunction

  // Single sample through empty dut_a with out_ready=1; checks 31 cycles of timing.
  task automatic a_single(input logic [7:0] tg);
    a_in_valid = 1'b1; a_in_tag = tg; a_in_dwell = 8'd3; a_out_ready = 1'b1;
    @(negedge clk);
    chk_val("a_single_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    for (int o = 1; o <= 31; o++) begin
      @(negedge clk);
      chk_val("a_single_valve", 64'(a_valve), 64'(exp_valve_a(o)));
      chk_val("a_single_out_valid", 64'(a_out_valid), 64'(o == 28));
      chk_val("a_single_out_tag", 64'(a_out_tag), (o == 28) ? 64'(tg) : 64'd0);
      chk_val("a_single_occ", 64'(a_occ), 64'(o <= 30));
      step();
    end
  endtask

  task automatic a_inject(input int cnt, input logic [7:0] base, input logic [7:0] dw, output int n);
    logic hs;
    n = 0;
    for (int c = 0; c < 300 && n < cnt; c++) begin
      a_in_valid = 1'b1; a_in_tag = base + 8'(n); a_in_dwell = dw;
      @(negedge clk);
      hs = a_in_ready;
      step();
      if (hs) n++;
    end
    a_in_valid = 1'b0;
  endtask

  int          n_acc, nrx, nin, nout, occ_exp;
  int          run [33];
  logic        hs_in, dec;
  logic [7:0]  et;

  initial begin
    repeat (2) step();
    @(negedge clk);
    chk_val("a_ready_in_reset", 64'(a_in_ready), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    step();
    @(negedge clk);
    chk_val("a_rst_valve", 64'(a_valve), 64'd0);
    chk_val("a_rst_occ", 64'(a_occ), 64'd0);
    chk_val("a_rst_busy", 64'(a_busy), 64'd0);
    chk_val("a_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk_val("a_rst_out_tag", 64'(a_out_tag), 64'd0);
    chk_val("a_rst_in_ready", 64'(a_in_ready), 64'd1);
    step();

    // Single sample, N=4 X=2 D=3
    a_single(8'hA5);

    // Back-pressure: four samples, collector stalled
    a_out_ready = 1'b0;
    a_inject(4, 8'h01, 8'h00, n_acc);
    chk_val("a_bp_injected", 64'(n_acc), 64'd4);
    repeat (80) step();
    @(negedge clk);
    chk_val("a_bp_occ", 64'(a_occ), 64'd4);
    chk_val("a_bp_busy", 64'(a_busy), 64'd1);
    chk_val("a_bp_in_ready", 64'(a_in_ready), 64'd0);
    chk_val("a_bp_out_valid", 64'(a_out_valid), 64'd1);
    chk_val("a_bp_head_tag", 64'(a_out_tag), 64'h01);
    step();
    a_out_ready = 1'b1;
    nrx = 0;
    for (int c = 0; c < 200 && nrx < 4; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        chk_val("a_bp_order", 64'(a_out_tag), 64'(nrx + 1));
        nrx++;
      end
      step();
    end
    chk_val("a_bp_count", 64'(nrx), 64'd4);
    repeat (20) step();
    @(negedge clk);
    chk_val("a_bp_drained", 64'(a_occ), 64'd0);
    step();

    // Pause for 10 cycles while chamber 1 is filling
    a_in_valid = 1'b1; a_in_tag = 8'h3C; a_in_dwell = 8'd3; a_out_ready = 1'b1;
    @(negedge clk);
    chk_val("a_pause_t0_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    repeat (7) step();
    a_pause = 1'b1;
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      chk_val("a_pause_valve", 64'(a_valve), 64'h02);
      chk_val("a_pause_occ", 64'(a_occ), 64'd1);
      chk_val("a_pause_in_ready", 64'(a_in_ready), 64'd0);
      chk_val("a_pause_out_valid", 64'(a_out_valid), 64'd0);
      step();
    end
    a_pause = 1'b0;
    for (int o = 18; o <= 41; o++) begin
      @(negedge clk);
      chk_val("a_resume_valve", 64'(a_valve), 64'(exp_valve_a(o - 10)));
      chk_val("a_resume_out_valid", 64'(a_out_valid), 64'(o == 38));
      if (o == 38) chk_val("a_resume_tag", 64'(a_out_tag), 64'h3C);
      chk_val("a_resume_occ", 64'(a_occ), 64'(o <= 40));
      step();
    end

    // Reset with three samples in flight
    a_out_ready = 1'b0;
    a_inject(3, 8'h10, 8'h03, n_acc);
    chk_val("a_rst_injected", 64'(n_acc), 64'd3);
    repeat (5) step();
    a_rst = 1'b1;
    step();
    @(negedge clk);
    chk_val("a_midrst_valve", 64'(a_valve), 64'd0);
    chk_val("a_midrst_occ", 64'(a_occ), 64'd0);
    chk_val("a_midrst_busy", 64'(a_busy), 64'd0);
    chk_val("a_midrst_out_valid", 64'(a_out_valid), 64'd0);
    chk_val("a_midrst_out_tag", 64'(a_out_tag), 64'd0);
    chk_val("a_midrst_in_ready", 64'(a_in_ready), 64'd0);
    step();
    a_rst = 1'b0;
    step();
    a_single(8'h77);

    // N=1, X=1, dwell=0
    b_in_valid = 1'b1; b_in_tag = 8'h11; b_in_dwell = 8'd0; b_out_ready = 1'b0;
    @(negedge clk);
    chk_val("b_t0_ready", 64'(b_in_ready), 64'd1);
    step();
    b_in_valid = 1'b0;
    for (int o = 1; o <= 5; o++) begin
      if (o == 3) b_out_ready = 1'b1;
      @(negedge clk);
      chk_val("b_valve", 64'(b_valve), (o == 1) ? 64'h1 : (o == 4) ? 64'h2 : 64'h0);
      chk_val("b_out_valid", 64'(b_out_valid), 64'(o == 3));
      chk_val("b_out_tag", 64'(b_out_tag), (o == 3) ? 64'h11 : 64'h0);
      chk_val("b_occ", 64'(b_occ), 64'(o <= 4));
      chk_val("b_in_ready", 64'(b_in_ready), 64'(o == 5));
      step();
    end

    // Default parameters: stream 32 samples, free-running collector
    for (int b = 0; b < 33; b++) run[b] = 0;
    nin = 0; nout = 0; occ_exp = 0;
    c_out_ready = 1'b1; c_in_dwell = 8'd2; c_in_tag = 8'h40; c_in_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs_in = c_in_valid && c_in_ready;
      chk_val("c_occ", 64'(c_occ), 64'(occ_exp));
      if (c_out_valid) begin
        et = 8'h40 + 8'(nout);
        chk_val("c_order", 64'(c_out_tag), 64'(et));
        nout++;
      end
      dec = 1'b0;
      for (int b = 0; b < 33; b++) begin
        if (c_valve[b]) run[b]++;
        else if (run[b] != 0) begin
          chk_val("c_pulse", 64'(run[b]), 64'd4);
          run[b] = 0;
        end
      end
      if (c_valve[32] && run[32] == 4) dec = 1'b1;
      if (nout == 32 && occ_exp == 0 && c_valve == '0) break;
      step();
      if (hs_in) begin
        occ_exp++;
        nin++;
      end
      if (dec) occ_exp--;
      c_in_valid = (nin < 32);
      c_in_tag   = 8'h40 + 8'(nin);
    end
    chk_val("c_in_count", 64'(nin), 64'd32);
    chk_val("c_out_count", 64'(nout), 64'd32);
    chk_val("c_final_busy", 64'(c_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
